accel_display_sequencer: RTL and testbench
==========================================

# accel_display_sequencer

Sequences the accelerometer snapshot onto the 16-bit hex display path. It sits between `mpu6050_controller` (the X/Y/Z sample source) and the four hex-digit decoders. It captures coherent X/Y/Z snapshots on each sample strobe, then picks one axis for display, either manually or by timed auto-scan. It also supports display freeze and, optionally, a stale-sensor flag.

## Interface
Parameters:
- `DW`, 16, sample and display width
- `DWELL_CYCLES`, 50_000_000, auto-scan dwell per axis in clk cycles (1 s at 50 MHz); must be ≥ 2
- `STALE_CYCLES`, 5_000_000, sample-gap threshold for `stale` (100 ms at 50 MHz)

Ports:
- `clk`  in  1  system clock (CLOCK_50 domain); one clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `sample_valid`  in  1  one-cycle strobe; `accel_x/y/z` valid in the same cycle
- `accel_x`  in  DW  X sample
- `accel_y`  in  DW  Y sample
- `accel_z`  in  DW  Z sample
- `auto_scan`  in  1  level; 1 = timed X→Y→Z rotation, 0 = manual
- `manual_sel`  in  2  0=X, 1=Y, 2=Z, 3=error pattern (used when `auto_scan`=0)
- `freeze`  in  1  level; holds display and snapshots
- `disp_data`  out  DW  value to hex decoders
- `disp_axis`  out  2  axis shown: 0=X, 1=Y, 2=Z, 3=none/error
- `disp_update`  out  1  one-cycle pulse when `disp_data` or `disp_axis` changed
- `stale`  out  1  no sample for `STALE_CYCLES` cycles (see Configuration)

## Operation
- **Snapshot registers** `snap_x/y/z`:
  - All three are loaded together on `sample_valid`=1 while `freeze`=0.
  - Samples arriving while `freeze`=1 are discarded; they are not queued.
- **State machine**:
  - **WAIT** (reset state):
    - `disp_data`=0, `disp_axis`=3.
    - An accepted sample (`sample_valid`=1 and `freeze`=0) → RUN.
    - `freeze` has no other effect in WAIT.
  - **RUN**:
    - Selection is recomputed every cycle from the current mode.
    - `freeze`=1 → HOLD.
  - **HOLD**:
    - Outputs, snapshots and the dwell counter are all frozen.
    - `freeze`=0 → RUN.
- **Manual mode** (`auto_scan`=0):
  - Selected axis = `manual_sel`.
  - `manual_sel`=3 gives `disp_data`=all ones (16'hFFFF) and `disp_axis`=3.
- **Auto-scan mode** (`auto_scan`=1):
  - 2-bit `scan_axis` cycles 0→1→2→0. Value 3 is never reached.
  - Dwell counter runs 0..DWELL_CYCLES-1 in RUN only. At the terminal count, `scan_axis` advances and the counter reloads 0.
  - A rising edge of `auto_scan` (0→1 across consecutive cycles) forces `scan_axis`=0 and counter=0.
  - `manual_sel` is ignored in this mode.
- **Auto → manual switch**: manual selection takes effect in the next registered output. `scan_axis` is retained but unused.
- **Sample strobe coincident with axis advance**: both take effect on the same edge. The display shows the new axis carrying the new sample value.
- **`disp_update`**: asserted in the cycle the registered `disp_data` or `disp_axis` first differs from its previous-cycle value. It is never asserted in HOLD.
- **Reset mid-operation**: all registers clear and the FSM returns to WAIT. A `sample_valid` in the reset cycle is ignored.

## Timing
- Values after reset: `disp_data`=0, `disp_axis`=3, `disp_update`=0, `stale`=0, snapshots=0, `scan_axis`=0, counters=0.
- Snapshot latency:
  - `sample_valid` in cycle N → snapshot register updated at the end of cycle N.
  - `disp_data` shows the new value in cycle N+1.
  - `disp_update`=1 in cycle N+1 if the value changed.
- Selection latency:
  - A `manual_sel`/`auto_scan` change in cycle N → outputs in cycle N+1.
  - `freeze` sampled in cycle N stops outputs changing from cycle N+1.
- Auto-scan:
  - Each axis is displayed for exactly `DWELL_CYCLES` consecutive RUN cycles.
  - HOLD cycles extend the dwell and are not counted.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration
- **`ACCEL_STALE_DETECT_EN` defined**:
  - Gap counter is cleared by any `sample_valid`, including one discarded under `freeze`.
  - Otherwise it increments, saturating at `STALE_CYCLES`.
  - `stale`=1 while counter == `STALE_CYCLES`, in all states including WAIT.
  - `stale` deasserts one cycle after the next `sample_valid`.
- **Not defined**: no gap counter is built; `stale` is tied to 0.

## Test plan
All scenarios use `DWELL_CYCLES`=8 and `STALE_CYCLES`=20.
- **Reset/WAIT**: hold `reset` 2 cycles, then no samples for 10 cycles → `disp_data`=0, `disp_axis`=3, `disp_update`=0 throughout.
- **Manual capture**:
  - `manual_sel`=1, strobe with X=1234h, Y=ABCDh, Z=0F0Fh → next cycle `disp_data`=ABCDh, `disp_axis`=1, one `disp_update` pulse.
  - Then `manual_sel`=3 → FFFFh, `disp_axis`=3.
- **Auto-scan**:
  - Raise `auto_scan` after the capture → `disp_axis` sequence 0,1,2,0 with changes exactly 8 cycles apart, each with a `disp_update` pulse.
  - A strobe on the advance edge → the new axis shows the new sample.
- **Freeze**:
  - Assert `freeze` for 5 cycles mid-dwell with a strobe (X=5555h) inside the window → outputs constant and no pulses while frozen.
  - After release, dwell resumes from the held count and X retains its pre-freeze value.
- **Stale (macro on)**:
  - No strobe for 20 cycles → `stale`=1.
  - A strobe (even under `freeze`) → `stale`=0 next cycle.
  - With the macro off, `stale` stays 0.
- **Reset mid-scan**: assert `reset` during auto-scan at `disp_axis`=2 → the next cycle shows WAIT outputs, and `scan_axis` restarts at 0 after the next sample.

Source files
------------

// File: rtl/accel_display_sequencer.sv
// Captures coherent X/Y/Z accelerometer snapshots and selects one axis for the hex display (manual or timed auto-scan).
// Optional stale-sensor detection is built only when ACCEL_STALE_DETECT_EN is defined; otherwise stale is tied low.
module accel_display_sequencer #(
    parameter int DW           = 16,
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int STALE_CYCLES = 5_000_000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sample_valid,
    input  logic [DW-1:0] accel_x,
    input  logic [DW-1:0] accel_y,
    input  logic [DW-1:0] accel_z,
    input  logic          auto_scan,
    input  logic [1:0]    manual_sel,
    input  logic          freeze,
    output logic [DW-1:0] disp_data,
    output logic [1:0]    disp_axis,
    output logic          disp_update,
    output logic          stale
);

    // state  | meaning
    // S_WAIT | no sample accepted since reset; display blank (axis 3)
    // S_RUN  | selection recomputed every cycle, dwell counter active
    // S_HOLD | freeze asserted; display, snapshots and dwell held
    typedef enum logic [1:0] {S_WAIT, S_RUN, S_HOLD} state_t;

    localparam int            CW         = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [DW-1:0] r_snap_x, r_snap_y, r_snap_z;
    logic [DW-1:0] w_snap_x_nxt, w_snap_y_nxt, w_snap_z_nxt;
    logic [1:0]    r_scan_axis, w_scan_nxt;
    logic [CW-1:0] r_dwell_cnt, w_cnt_nxt;
    logic          r_auto_d;
    logic [DW-1:0] r_disp_data, w_data_nxt, w_sel_data;
    logic [1:0]    r_disp_axis, w_axis_nxt, w_sel;
    logic          r_disp_update, w_upd_nxt;
    logic          w_accept, w_run, w_load, w_rise;

    assign w_accept = sample_valid & ~freeze;
    assign w_run    = (r_state != S_WAIT) & ~freeze;
    // The accepting sample in WAIT also drives the display so it appears on the next cycle.
    assign w_load   = w_run | ((r_state == S_WAIT) & w_accept);
    assign w_rise   = auto_scan & ~r_auto_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_WAIT;
            r_snap_x      <= '0;
            r_snap_y      <= '0;
            r_snap_z      <= '0;
            r_scan_axis   <= 2'd0;
            r_dwell_cnt   <= '0;
            r_auto_d      <= 1'b0;
            r_disp_data   <= '0;
            r_disp_axis   <= 2'd3;
            r_disp_update <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_snap_x      <= w_snap_x_nxt;
            r_snap_y      <= w_snap_y_nxt;
            r_snap_z      <= w_snap_z_nxt;
            r_scan_axis   <= w_scan_nxt;
            r_dwell_cnt   <= w_cnt_nxt;
            r_auto_d      <= auto_scan;
            r_disp_data   <= w_data_nxt;
            r_disp_axis   <= w_axis_nxt;
            r_disp_update <= w_upd_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_snap_x_nxt = r_snap_x;
        w_snap_y_nxt = r_snap_y;
        w_snap_z_nxt = r_snap_z;
        w_scan_nxt   = r_scan_axis;
        w_cnt_nxt    = r_dwell_cnt;
        w_sel        = 2'd3;
        w_sel_data   = '1;
        w_data_nxt   = r_disp_data;
        w_axis_nxt   = r_disp_axis;
        w_upd_nxt    = 1'b0;

        case (r_state)
            S_WAIT:  if (w_accept) w_state_nxt = S_RUN;
            S_RUN:   if (freeze)   w_state_nxt = S_HOLD;
            S_HOLD:  if (!freeze)  w_state_nxt = S_RUN;
            default: w_state_nxt = S_WAIT;
        endcase

        if (w_accept) begin
            w_snap_x_nxt = accel_x;
            w_snap_y_nxt = accel_y;
            w_snap_z_nxt = accel_z;
        end

        if (w_run && auto_scan) begin
            if (w_rise) begin
                w_scan_nxt = 2'd0;
                w_cnt_nxt  = '0;
            end else if (r_dwell_cnt == DWELL_LAST) begin
                w_cnt_nxt  = '0;
                w_scan_nxt = (r_scan_axis == 2'd2) ? 2'd0 : 2'(r_scan_axis + 2'd1);
            end else begin
                w_cnt_nxt  = r_dwell_cnt + CW'(1);
            end
        end

        // Selection uses next-cycle snapshot/axis so a strobe on an advance edge shows up with the new axis.
        w_sel = auto_scan ? w_scan_nxt : manual_sel;
        case (w_sel)
            2'd0:    w_sel_data = w_snap_x_nxt;
            2'd1:    w_sel_data = w_snap_y_nxt;
            2'd2:    w_sel_data = w_snap_z_nxt;
            default: w_sel_data = '1;
        endcase

        if (w_load) begin
            w_data_nxt = w_sel_data;
            w_axis_nxt = w_sel;
            w_upd_nxt  = (w_sel_data != r_disp_data) || (w_sel != r_disp_axis);
        end
    end

    assign disp_data   = r_disp_data;
    assign disp_axis   = r_disp_axis;
    assign disp_update = r_disp_update;

`ifdef ACCEL_STALE_DETECT_EN
    localparam int            SW        = (STALE_CYCLES > 0) ? $clog2(STALE_CYCLES + 1) : 1;
    localparam logic [SW-1:0] STALE_MAX = SW'(STALE_CYCLES);

    logic [SW-1:0] r_gap_cnt, w_gap_nxt;
    logic          r_stale;

    // Any strobe counts as sensor activity, even one discarded under freeze.
    always_comb begin
        w_gap_nxt = r_gap_cnt;
        if (sample_valid)
            w_gap_nxt = '0;
        else if (r_gap_cnt != STALE_MAX)
            w_gap_nxt = r_gap_cnt + SW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_gap_cnt <= '0;
            r_stale   <= 1'b0;
        end else begin
            r_gap_cnt <= w_gap_nxt;
            r_stale   <= (w_gap_nxt == STALE_MAX);
        end
    end

    assign stale = r_stale;
`else
    assign stale = 1'b0;
`endif

endmodule

// File: tb/tb_accel_display_sequencer.sv
// Self-checking bench for accel_display_sequencer: directed scenarios plus random traffic against a cycle-level reference model.
// Stale expectations follow ACCEL_STALE_DETECT_EN, the same macro that builds the detector in the design.
module tb_accel_display_sequencer;

    localparam int DW    = 16;
    localparam int DWELL = 8;
    localparam int STALE = 20;
`ifdef ACCEL_STALE_DETECT_EN
    localparam bit STALE_EN = 1'b1;
`else
    localparam bit STALE_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, sample_valid, auto_scan, freeze;
    logic [DW-1:0] accel_x, accel_y, accel_z;
    logic [1:0]    manual_sel;
    logic [DW-1:0] disp_data;
    logic [1:0]    disp_axis;
    logic          disp_update, stale;

    always #5 clk = ~clk;

    accel_display_sequencer #(
        .DW(DW), .DWELL_CYCLES(DWELL), .STALE_CYCLES(STALE)
    ) dut (
        .clk(clk), .reset(reset), .sample_valid(sample_valid),
        .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z),
        .auto_scan(auto_scan), .manual_sel(manual_sel), .freeze(freeze),
        .disp_data(disp_data), .disp_axis(disp_axis),
        .disp_update(disp_update), .stale(stale)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: "shown" is what the display should hold; dwell measured as used RUN cycles on the current axis.
    logic [DW-1:0] m_snap [3];
    int            m_scan, m_used, m_gap, m_axis;
    bit            m_started, m_prev_auto, m_upd, m_stale;
    logic [DW-1:0] m_disp;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_snap[i] = '0;
        m_scan = 0; m_used = 0; m_gap = 0; m_axis = 3;
        m_started = 0; m_prev_auto = 0; m_upd = 0; m_stale = 0;
        m_disp = '0;
    endtask

    task automatic model_update();
        bit accept, live, load;
        int sel;
        logic [DW-1:0] val;
        if (reset) begin
            model_reset();
            return;
        end
        accept = sample_valid && !freeze;
        if (sample_valid) m_gap = 0;
        else if (m_gap < STALE) m_gap++;
        m_stale = STALE_EN && (m_gap == STALE);
        live = m_started && !freeze;
        load = live || accept;
        if (accept) begin
            m_snap[0] = accel_x; m_snap[1] = accel_y; m_snap[2] = accel_z;
        end
        if (live && auto_scan) begin
            if (!m_prev_auto) begin
                m_scan = 0; m_used = 0;
            end else begin
                m_used++;
                if (m_used == DWELL) begin
                    m_used = 0;
                    m_scan = (m_scan + 1) % 3;
                end
            end
        end
        m_upd = 0;
        if (load) begin
            sel = auto_scan ? m_scan : int'(manual_sel);
            val = (sel == 3) ? 16'hFFFF : m_snap[sel];
            m_upd  = (val != m_disp) || (sel != m_axis);
            m_disp = val;
            m_axis = sel;
        end
        if (accept) m_started = 1;
        m_prev_auto = auto_scan;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        chk("disp_data", disp_data, m_disp);
        chk("disp_axis", disp_axis, m_axis);
        chk("disp_update", disp_update, m_upd);
        chk("stale", stale, m_stale);
    endtask

    task automatic strobe(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic [DW-1:0] z);
        sample_valid = 1'b1; accel_x = x; accel_y = y; accel_z = z;
    endtask

    logic [DW-1:0] held_data;
    logic [1:0]    held_axis;

    initial begin
        model_reset();
        reset = 1'b1; sample_valid = 1'b0; auto_scan = 1'b0; freeze = 1'b0;
        manual_sel = 2'd0; accel_x = '0; accel_y = '0; accel_z = '0;

        // Reset and idle WAIT
        step(); step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("wait_data", disp_data, 16'h0000);
        chk("wait_axis", disp_axis, 2'd3);

        // Manual capture
        manual_sel = 2'd1;
        strobe(16'h1234, 16'hABCD, 16'h0F0F);
        step();
        sample_valid = 1'b0;
        chk("man_data", disp_data, 16'hABCD);
        chk("man_axis", disp_axis, 2'd1);
        chk("man_pulse", disp_update, 1'b1);
        step();
        chk("man_nopulse", disp_update, 1'b0);
        manual_sel = 2'd3;
        step();
        chk("err_data", disp_data, 16'hFFFF);
        chk("err_axis", disp_axis, 2'd3);

        // Auto-scan: axis changes every DWELL cycles
        auto_scan = 1'b1;
        step();
        chk("as_x_data", disp_data, 16'h1234);
        chk("as_x_axis", disp_axis, 2'd0);
        for (int i = 0; i < DWELL - 1; i++) begin
            step();
            chk("as_x_hold", disp_axis, 2'd0);
        end
        step();
        chk("as_y_axis", disp_axis, 2'd1);
        chk("as_y_pulse", disp_update, 1'b1);
        for (int i = 0; i < DWELL - 2; i++) step();
        chk("as_y_hold", disp_axis, 2'd1);
        step();
        strobe(16'h1234, 16'hABCD, 16'h7777);
        step();
        sample_valid = 1'b0;
        chk("adv_strobe_axis", disp_axis, 2'd2);
        chk("adv_strobe_data", disp_data, 16'h7777);
        for (int i = 0; i < DWELL; i++) step();
        chk("as_wrap_axis", disp_axis, 2'd0);

        // Freeze mid-dwell with a discarded strobe
        for (int i = 0; i < 3; i++) step();
        held_data = disp_data;
        held_axis = disp_axis;
        freeze = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) strobe(16'h5555, 16'h5555, 16'h5555);
            step();
            sample_valid = 1'b0;
            chk("frz_data", disp_data, held_data);
            chk("frz_axis", disp_axis, held_axis);
            chk("frz_pulse", disp_update, 1'b0);
        end
        freeze = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rel_axis", disp_axis, 2'd0);
            chk("rel_x_kept", disp_data, 16'h1234);
        end
        step();
        chk("rel_adv", disp_axis, 2'd1);

        // Stale detection
        for (int i = 0; i < STALE + 1; i++) step();
        chk("stale_set", stale, STALE_EN);
        freeze = 1'b1;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        freeze = 1'b0;
        chk("stale_clr", stale, 1'b0);

        // Reset mid-scan at Z
        for (int i = 0; i < 40 && m_axis != 2; i++) step();
        chk("reach_z", disp_axis, 2'd2);
        reset = 1'b1;
        strobe(16'h9999, 16'h9999, 16'h9999);
        step();
        chk("rst_data", disp_data, 16'h0000);
        chk("rst_axis", disp_axis, 2'd3);
        reset = 1'b0;
        sample_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("rst_wait_axis", disp_axis, 2'd3);
        strobe(16'h2468, 16'h1357, 16'hBEEF);
        step();
        sample_valid = 1'b0;
        chk("rst_restart_axis", disp_axis, 2'd0);
        chk("rst_restart_data", disp_data, 16'h2468);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            reset        = ($urandom_range(0, 199) == 0);
            sample_valid = ($urandom_range(0, 3) == 0);
            accel_x      = DW'($urandom);
            accel_y      = DW'($urandom);
            accel_z      = DW'($urandom);
            if ($urandom_range(0, 29) == 0) auto_scan = ~auto_scan;
            if ($urandom_range(0, 7) == 0)  freeze = ~freeze;
            if ($urandom_range(0, 9) == 0)  manual_sel = 2'($urandom_range(0, 3));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
